// File: rtl/rtdf_packet_parser_pkg.sv
// Shared definitions for the RT data feed packet parser: state encoding,
// header geometry and the wire byte-swap helper.
package rtdf_packet_parser_pkg;

  localparam int RTDF_HDR_WORDS = 7;
  localparam int RTDF_HDR_BYTES = 16;

  typedef enum logic [2:0] {
    ST_LENGTH  = 3'd0,
    ST_HDR     = 3'd1,
    ST_SEQ     = 3'd2,
    ST_DATA    = 3'd3,
    ST_TAIL    = 3'd4,
    ST_DISCARD = 3'd5
  } state_e;

  // Header fields arrive first-byte-in-low-half; this restores network order.
  function automatic logic [15:0] bswap16(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/rtdf_packet_parser_if.sv
// Payload stream: valid/ready, a word transfers on a clock edge where valid && ready;
// the master holds data/last/odd stable while valid && !ready.
interface rtdf_packet_parser_if;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        last;
  logic        odd;

  modport master (output data, valid, last, odd, input ready);
  modport slave  (input data, valid, last, odd, output ready);
endinterface

// File: rtl/rtdf_out_stage.sv
// One-entry output register for the payload stream; holds its word until accepted.
module rtdf_out_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [15:0] data_i,
  input  logic        last_i,
  input  logic        odd_i,
  output logic        can_load_o,
  rtdf_packet_parser_if.master out
);

  logic [15:0] data_q;
  logic        valid_q;
  logic        last_q;
  logic        odd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= 16'h0;
      last_q  <= 1'b0;
      odd_q   <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
      odd_q   <= odd_i;
    end else if (out.ready) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      odd_q   <= 1'b0;
    end
  end

  assign can_load_o = !valid_q || out.ready;
  assign out.data   = data_q;
  assign out.valid  = valid_q;
  assign out.last   = last_q;
  assign out.odd    = odd_q;

endmodule

// File: rtl/rtdf_packet_parser.sv
// RT data feed packet parser: strips header/FCS from RX FIFO frames and streams payload.
// Optional destination MAC filtering is enabled by defining RTDF_MAC_FILTER_EN.
module rtdf_packet_parser
  import rtdf_packet_parser_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          CRC_BYTES = 4,
  parameter int          LEN_W     = 11,
  parameter int          CNT_W     = 16,
  parameter logic [47:0] LOCAL_MAC = 48'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      in_data,
  input  logic             in_empty,
  output logic             in_rd_req,
  rtdf_packet_parser_if.master out,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] seq_err_count,
  output state_e           dbg_state_o
);

  localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(RTDF_HDR_BYTES + CRC_BYTES);
  localparam logic [LEN_W-1:0] ONE_W    = LEN_W'(1);
  localparam logic [2:0]       HDR_LAST = 3'(RTDF_HDR_WORDS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] pay_words_q, pay_words_d;
  logic             pay_odd_q, pay_odd_d;
  logic             drop_q, drop_d;
  logic [15:0]      exp_seq_q, exp_seq_d;
  logic             seq_valid_q, seq_valid_d;
  logic [CNT_W-1:0] pkt_q, pkt_d, drop_cnt_q, drop_cnt_d, seq_err_q, seq_err_d;

  logic             load, ld_last, ld_odd, can_load;
  logic [15:0]      word;
  logic [LEN_W-1:0] len, total_words, pay_bytes, pay_words, rem_dec;
  logic [LEN_W:0]   len_p1, pb_p1;

  assign word        = bswap16(in_data);
  assign len         = in_data[LEN_W-1:0];
  assign len_p1      = {1'b0, len} + 1'b1;
  assign total_words = len_p1[LEN_W:1];
  assign pay_bytes   = len - MIN_LEN;
  assign pb_p1       = {1'b0, pay_bytes} + 1'b1;
  assign pay_words   = pb_p1[LEN_W:1];
  assign rem_dec     = rem_q - ONE_W;

  // The output register only gates consumption while payload is flowing.
  assign in_rd_req = !in_empty && (state_q != ST_DATA || can_load);

`ifdef RTDF_MAC_FILTER_EN
  logic        mac_eq_q, mac_eq_d, mac_bc_q, mac_bc_d;
  logic [15:0] mac_chunk;

  always_comb begin
    case (hdr_cnt_q)
      3'd0:    mac_chunk = LOCAL_MAC[47:32];
      3'd1:    mac_chunk = LOCAL_MAC[31:16];
      default: mac_chunk = LOCAL_MAC[15:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mac_eq_q <= 1'b0;
      mac_bc_q <= 1'b0;
    end else begin
      mac_eq_q <= mac_eq_d;
      mac_bc_q <= mac_bc_d;
    end
  end
`else
  logic unused_mac;
  assign unused_mac = ^LOCAL_MAC;
`endif

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    rem_d       = rem_q;
    pay_words_d = pay_words_q;
    pay_odd_d   = pay_odd_q;
    drop_d      = drop_q;
    exp_seq_d   = exp_seq_q;
    seq_valid_d = seq_valid_q;
    pkt_d       = pkt_q;
    drop_cnt_d  = drop_cnt_q;
    seq_err_d   = seq_err_q;
    load        = 1'b0;
    ld_last     = 1'b0;
    ld_odd      = 1'b0;
`ifdef RTDF_MAC_FILTER_EN
    mac_eq_d    = mac_eq_q;
    mac_bc_d    = mac_bc_q;
`endif
    if (in_rd_req) begin
      case (state_q)
        ST_LENGTH: begin
          if (len != '0) begin
            rem_d       = total_words;
            hdr_cnt_d   = 3'd0;
            drop_d      = 1'b0;
            pay_words_d = pay_words;
            pay_odd_d   = pay_bytes[0];
            if (len < MIN_LEN) begin
              drop_cnt_d = sat_inc(drop_cnt_q);
              state_d    = ST_DISCARD;
            end else begin
              state_d    = ST_HDR;
            end
          end
        end
        ST_HDR: begin
          rem_d     = rem_dec;
          hdr_cnt_d = hdr_cnt_q + 3'd1;
`ifdef RTDF_MAC_FILTER_EN
          // Unicast and broadcast matches are tracked in parallel over DST0..DST2.
          if (hdr_cnt_q < 3'd3) begin
            mac_eq_d = (word == mac_chunk) && (mac_eq_q || hdr_cnt_q == 3'd0);
            mac_bc_d = (word == 16'hFFFF) && (mac_bc_q || hdr_cnt_q == 3'd0);
            if (hdr_cnt_q == 3'd2 && !(mac_eq_d || mac_bc_d)) drop_d = 1'b1;
          end
`endif
          if (hdr_cnt_q == HDR_LAST) begin
            if (word != ETHERTYPE) drop_d = 1'b1;
            state_d = ST_SEQ;
          end
        end
        ST_SEQ: begin
          rem_d = rem_dec;
          if (drop_q) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
          end else begin
            pkt_d = sat_inc(pkt_q);
            if (seq_valid_q && word != exp_seq_q) seq_err_d = sat_inc(seq_err_q);
            exp_seq_d   = word + 16'd1;
            seq_valid_d = 1'b1;
          end
          if (drop_q || pay_words_q == '0) state_d = (rem_dec == '0) ? ST_LENGTH : ST_TAIL;
          else                             state_d = ST_DATA;
        end
        ST_DATA: begin
          rem_d       = rem_dec;
          pay_words_d = pay_words_q - ONE_W;
          load        = 1'b1;
          ld_last     = (pay_words_q == ONE_W);
          ld_odd      = ld_last && pay_odd_q;
          if (ld_last) state_d = (rem_dec == '0) ? ST_LENGTH : ST_TAIL;
        end
        ST_TAIL, ST_DISCARD: begin
          rem_d = rem_dec;
          if (rem_dec == '0) state_d = ST_LENGTH;
        end
        default: state_d = ST_LENGTH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LENGTH;
      hdr_cnt_q   <= 3'd0;
      rem_q       <= '0;
      pay_words_q <= '0;
      pay_odd_q   <= 1'b0;
      drop_q      <= 1'b0;
      exp_seq_q   <= 16'h0;
      seq_valid_q <= 1'b0;
      pkt_q       <= '0;
      drop_cnt_q  <= '0;
      seq_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      rem_q       <= rem_d;
      pay_words_q <= pay_words_d;
      pay_odd_q   <= pay_odd_d;
      drop_q      <= drop_d;
      exp_seq_q   <= exp_seq_d;
      seq_valid_q <= seq_valid_d;
      pkt_q       <= pkt_d;
      drop_cnt_q  <= drop_cnt_d;
      seq_err_q   <= seq_err_d;
    end
  end

  rtdf_out_stage u_out_stage (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .data_i     (in_data),
    .last_i     (ld_last),
    .odd_i      (ld_odd),
    .can_load_o (can_load),
    .out        (out)
  );

  assign pkt_count     = pkt_q;
  assign drop_count    = drop_cnt_q;
  assign seq_err_count = seq_err_q;
  assign dbg_state_o   = state_q;

endmodule
